// File: rtl/utpu_isa_pkg.sv
// Shared ISA definitions for the micro-TPU: opcode encoding, word geometry and
// instruction field-slice helpers used by the fetch unit and the controller.
package utpu_isa_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned IMM_BIT  = 4;
  localparam int unsigned BYTE_W   = 8;

  typedef enum logic [OPCODE_W-1:0] {
    STORE = 3'd0,
    FETCH = 3'd1,
    RUN   = 3'd2,
    LOAD  = 3'd3,
    HALT  = 3'd4,
    NOP   = 3'd5
  } opcode_t;

  // Opcode field of an instruction word.
  function automatic logic [OPCODE_W-1:0] instr_opcode(input logic [WORD_W-1:0] instr);
    return instr[OPCODE_W-1:0];
  endfunction

  // STORE carrying a trailing immediate data word.
  function automatic logic instr_has_imm(input logic [WORD_W-1:0] instr);
    return (instr[OPCODE_W-1:0] == STORE) && instr[IMM_BIT];
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: pops bytes from the UART RX FIFO, assembles 16-bit
// instruction words (low byte first), fetches the immediate word of STORE-imm,
// drops NOPs, and presents {instr_word, data_word} on a valid/ready handshake.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 pulse: begin fetching from IDLE or HALTED
//   rx_empty/rx_re/rx_data RX FIFO read port (data valid the cycle after rx_re)
//   instr_valid/instr_ready handshake toward the controller
//   instr_word, data_word, has_data  issued payload
//   halted, busy, instr_count        status
module instr_fetch_unit
  import utpu_isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_empty,
  output logic              rx_re,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr_word,
  output logic [WORD_W-1:0] data_word,
  output logic              has_data,
  output logic              halted,
  output logic              busy,
  output logic [WORD_W-1:0] instr_count
);

  localparam int unsigned BUF_DEPTH = 4;

  typedef enum logic [2:0] {IDLE, POP, WAIT, ISSUE, HALTED} ifu_state_t;

  ifu_state_t        state, next_state;
  logic [1:0]        byte_cnt;
  logic [BYTE_W-1:0] byte_buf [BUF_DEPTH];
  logic              need;
  logic [WORD_W-1:0] pair_word;

  // Word formed by byte 0 and the byte arriving this cycle.
  assign pair_word = {rx_data, byte_buf[0]};

  // Next-state logic. POP leaves only once the registered read strobe is out,
  // so exactly one FIFO read is outstanding at a time.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start) next_state = POP;
      POP:    if (rx_re) next_state = WAIT;
      WAIT: begin
        if (byte_cnt == 2'd1) begin
          if (opcode_t'(instr_opcode(pair_word)) == NOP) next_state = POP;
          else if (instr_has_imm(pair_word))               next_state = POP;
          else                                             next_state = ISSUE;
        end else if (need && byte_cnt == 2'd3) begin
          next_state = ISSUE;
        end else begin
          next_state = POP;
        end
      end
      ISSUE:  if (instr_ready)
                next_state = (opcode_t'(instr_opcode(instr_word)) == HALT) ? HALTED : POP;
      HALTED: if (start) next_state = POP;
      default: next_state = IDLE;
    endcase
  end

  // State, byte assembly and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rx_re       <= 1'b0;
      instr_valid <= 1'b0;
      instr_word  <= '0;
      data_word   <= '0;
      has_data    <= 1'b0;
      halted      <= 1'b0;
      busy        <= 1'b0;
      instr_count <= '0;
      byte_cnt    <= '0;
      need        <= 1'b0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) byte_buf[i] <= '0;
    end else begin
      state       <= next_state;
      // FIFO can only drain through our own reads, so a non-empty flag seen
      // now still holds in the cycle the strobe is presented.
      rx_re       <= (next_state == POP) && !rx_empty;
      instr_valid <= (next_state == ISSUE);
      halted      <= (next_state == HALTED);
      busy        <= (next_state != IDLE) && (next_state != HALTED);

      if (state == WAIT) begin
        byte_buf[byte_cnt] <= rx_data;
        byte_cnt           <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd1) begin
          if (opcode_t'(instr_opcode(pair_word)) == NOP) byte_cnt <= 2'd0;
          if (instr_has_imm(pair_word))                  need     <= 1'b1;
        end
        if (next_state == ISSUE) begin
          if (byte_cnt == 2'd3) begin
            instr_word <= {byte_buf[1], byte_buf[0]};
            data_word  <= {rx_data, byte_buf[2]};
            has_data   <= 1'b1;
          end else begin
            instr_word <= pair_word;
            data_word  <= '0;
            has_data   <= 1'b0;
          end
        end
      end

      if (state == ISSUE && instr_ready) begin
        instr_count <= instr_count + WORD_W'(1);
        byte_cnt    <= 2'd0;
        need        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: byte-stream reference model feeding a scoreboard,
// a FIFO model on the read port, and a monitor that checks every issued word.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_empty = 1'b1;
  logic        rx_re;
  logic [7:0]  rx_data = 8'h00;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_word, data_word, instr_count;
  logic        has_data, halted, busy;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .rx_empty(rx_empty), .rx_re(rx_re),
    .rx_data(rx_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_word(instr_word), .data_word(data_word), .has_data(has_data),
    .halted(halted), .busy(busy), .instr_count(instr_count)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] data;
    logic        has;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] acc[$];
  logic [7:0] fifo[$];
  logic [7:0] feed_q[$];
  int feed_pct = 100;
  int ready_pct = 100;
  int passed = 0;
  int total = 0;
  int model_total = 0;
  int rx_pulses = 0;
  int violations = 0;
  int rst_re_hits = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Stream-level model: every two bytes form a word; NOP words vanish,
  // STORE with the immediate flag swallows the next two bytes as data.
  task automatic model_push(input logic [7:0] b);
    logic [15:0] w;
    exp_t e;
    acc.push_back(b);
    while (acc.size() >= 2) begin
      w = {acc[1], acc[0]};
      if (w[2:0] == 3'd5) begin
        void'(acc.pop_front()); void'(acc.pop_front());
      end else if (w[2:0] == 3'd0 && w[4]) begin
        if (acc.size() < 4) break;
        e.instr = w; e.data = {acc[3], acc[2]}; e.has = 1'b1;
        exp_q.push_back(e);
        model_total++;
        repeat (4) void'(acc.pop_front());
      end else begin
        e.instr = w; e.data = 16'h0; e.has = 1'b0;
        exp_q.push_back(e);
        model_total++;
        void'(acc.pop_front()); void'(acc.pop_front());
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    feed_q.push_back(b);
    model_push(b);
  endtask

  // RX FIFO model: registered empty flag, read data the cycle after rx_re.
  always @(posedge clk) begin
    if (rx_re === 1'b1) begin
      rx_pulses++;
      if (rx_empty) violations++;
      if (fifo.size() > 0) rx_data <= fifo.pop_front();
    end
    if (rst && rx_re === 1'b1) rst_re_hits++;
    if (feed_q.size() > 0 && $urandom_range(99) < feed_pct)
      fifo.push_back(feed_q.pop_front());
    rx_empty <= (fifo.size() == 0);
  end

  always @(posedge clk) begin
    #1;
    instr_ready = ($urandom_range(99) < ready_pct);
  end

  // Monitor: pops the scoreboard on each handshake, checks hold stability.
  exp_t held;
  logic held_v = 1'b0;
  logic halt_chk = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_v   = 1'b0;
      halt_chk = 1'b0;
    end else begin
      if (halt_chk) begin
        check("halted_after_halt", halted, 1'b1);
        halt_chk = 1'b0;
      end
      if (instr_valid) begin
        if (held_v)
          check("hold_stable", {instr_word, data_word, has_data}, held);
        if (instr_ready) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_issue", instr_word, 16'hxxxx);
          end else begin
            e = exp_q.pop_front();
            check("instr_word", instr_word, e.instr);
            check("data_word", data_word, e.data);
            check("has_data", has_data, e.has);
            if (e.instr[2:0] == 3'd4) halt_chk = 1'b1;
          end
        end else begin
          held_v = 1'b1;
          held.instr = instr_word; held.data = data_word; held.has = has_data;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || instr_valid) && n < 20000) begin
      @(negedge clk); n++;
    end
    check(nm, (n < 20000), 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int p0, n;
    logic [15:0] w;

    // Reset
    repeat (10) @(negedge clk);
    check("reset_outputs",
          {rx_re, instr_valid, has_data, halted, busy, instr_word, data_word, instr_count}, 64'h0);
    check("reset_no_rx_re", rst_re_hits, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic RUN with latency
    send(8'h02); send(8'h00);
    repeat (4) @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("latency_not_early", instr_valid, 1'b0);
    @(negedge clk);
    check("latency_5", instr_valid, 1'b1);
    wait_drain("drain_basic");
    check("count_basic", instr_count, 16'(model_total));

    // STORE-imm
    p0 = rx_pulses;
    send(8'h10); send(8'h09); send(8'hDE); send(8'hAD);
    wait_drain("drain_store");
    check("store_rx_pulses", rx_pulses - p0, 4);

    // NOP, HALT, then RUN left queued
    send(8'h05); send(8'h00); send(8'h04); send(8'h00); send(8'h02); send(8'h00);
    n = 0;
    while (!halted && n < 2000) begin @(negedge clk); n++; end
    check("halt_reached", halted, 1'b1);
    p0 = rx_pulses;
    repeat (20) @(negedge clk);
    check("halted_no_rx_re", rx_pulses - p0, 0);
    check("halted_fifo_kept", rx_empty, 1'b0);
    check("halted_busy", busy, 1'b0);
    pulse_start();
    wait_drain("drain_after_halt");
    check("halted_cleared", halted, 1'b0);

    // Backpressure
    ready_pct = 0;
    p0 = rx_pulses;
    send(8'h02); send(8'h00); send(8'h01); send(8'h00);
    repeat (50) @(negedge clk);
    check("bp_valid", instr_valid, 1'b1);
    check("bp_no_rx_re", rx_pulses - p0, 2);
    ready_pct = 100;
    wait_drain("drain_bp");

    // Starvation mid-word
    send(8'h03);
    repeat (20) @(negedge clk);
    check("starve_busy", busy, 1'b1);
    check("starve_no_valid", instr_valid, 1'b0);
    send(8'h00);
    wait_drain("drain_starve");
    check("count_mid", instr_count, 16'(model_total));

    // Reset mid-word: first byte popped then lost
    p0 = rx_pulses;
    feed_q.push_back(8'h03);
    n = 0;
    while (rx_pulses == p0 && n < 200) begin @(negedge clk); n++; end
    check("rst_byte_popped", rx_pulses - p0, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_idle", {busy, instr_valid, instr_count}, 64'h0);
    acc.delete();
    model_total = 0;
    rst = 1'b0;
    send(8'h01); send(8'h00);
    repeat (3) @(negedge clk);
    pulse_start();
    wait_drain("drain_rst");
    check("count_rst", instr_count, 16'(model_total));

    // Randomized stream, random FIFO gaps and backpressure
    feed_pct = 60;
    ready_pct = 70;
    for (int i = 0; i < 150; i++) begin
      w = 16'($urandom);
      case ($urandom_range(6))
        0: w[2:0] = 3'd0;
        1: w[2:0] = 3'd1;
        2: w[2:0] = 3'd2;
        3: w[2:0] = 3'd3;
        4: w[2:0] = 3'd5;
        5: w[2:0] = 3'd6;
        default: w[2:0] = 3'd7;
      endcase
      send(w[7:0]); send(w[15:8]);
      if (w[2:0] == 3'd0 && w[4]) begin
        send(8'($urandom)); send(8'($urandom));
      end
    end
    wait_drain("drain_random");
    check("count_random", instr_count, 16'(model_total));
    check("no_read_while_empty", violations, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
